// File: rtl/mem_arbiter.sv
// mem_arbiter: I/D cache miss-fill arbiter issuing 8-word pipelined reads.
// Define ARB_ROUND_ROBIN_EN to alternate tie-breaks instead of fixed dcache priority.
module mem_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        icache_req,
   input  logic [15:0] icache_addr,
   input  logic        dcache_req,
   input  logic [15:0] dcache_addr,
   input  logic        mem_data_valid,
   output logic        mem_en,
   output logic [15:0] mem_addr,
   output logic        icache_grant,
   output logic        dcache_grant,
   output logic        fill_valid,
   output logic [2:0]  fill_offset,
   output logic        fill_done,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

   state_t      state;
   logic [11:0] blk;
   logic [2:0]  issue_cnt;
   logic [2:0]  ret_cnt;
   logic        pick_d;

   // Byte offsets within a block never reach memory.
   logic unused_offset;
   assign unused_offset = ^{icache_addr[3:0], dcache_addr[3:0]};

`ifdef ARB_ROUND_ROBIN_EN
   logic rr_ptr;

   assign pick_d = dcache_req & (~icache_req | ~rr_ptr);

   // The pointer names who wins the next tie: 0 = dcache, 1 = icache.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= 1'b0;
      end else if (state == DONE) begin
         rr_ptr <= dcache_grant;
      end
   end
`else
   assign pick_d = dcache_req;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         blk          <= '0;
         issue_cnt    <= '0;
         ret_cnt      <= '0;
         mem_en       <= 1'b0;
         icache_grant <= 1'b0;
         dcache_grant <= 1'b0;
         fill_done    <= 1'b0;
      end else begin
         fill_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (icache_req | dcache_req) begin
                  state        <= FILL;
                  blk          <= pick_d ? dcache_addr[15:4]
                                         : icache_addr[15:4];
                  dcache_grant <= pick_d;
                  icache_grant <= ~pick_d;
                  issue_cnt    <= '0;
                  ret_cnt      <= '0;
                  mem_en       <= 1'b1;
               end
            end
            FILL: begin
               if (mem_en) begin
                  issue_cnt <= issue_cnt + 3'd1;
                  if (issue_cnt == 3'd7) begin
                     mem_en <= 1'b0;
                  end
               end
               if (mem_data_valid) begin
                  ret_cnt <= ret_cnt + 3'd1;
                  if (ret_cnt == 3'd7) begin
                     state     <= DONE;
                     fill_done <= 1'b1;
                  end
               end
            end
            DONE: begin
               state        <= IDLE;
               icache_grant <= 1'b0;
               dcache_grant <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign mem_addr    = {blk, issue_cnt, 1'b0};
   assign fill_offset = ret_cnt;
   assign fill_valid  = mem_data_valid & (state == FILL);
   assign busy        = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized bench for mem_arbiter with a phase-level model
// of each fill and a 4-cycle pipelined memory.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        icache_req, dcache_req, mem_data_valid;
   logic [15:0] icache_addr, dcache_addr;
   logic        mem_en, icache_grant, dcache_grant;
   logic        fill_valid, fill_done, busy;
   logic [15:0] mem_addr;
   logic [2:0]  fill_offset;

   mem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .icache_req(icache_req), .icache_addr(icache_addr),
      .dcache_req(dcache_req), .dcache_addr(dcache_addr),
      .mem_data_valid(mem_data_valid),
      .mem_en(mem_en), .mem_addr(mem_addr),
      .icache_grant(icache_grant), .dcache_grant(dcache_grant),
      .fill_valid(fill_valid), .fill_offset(fill_offset),
      .fill_done(fill_done), .busy(busy)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;

   // Model: phase = cycles since the grant edge (0..12), -1 when idle.
   int          phase = -1;
   bit          owner_d = 1'b0;
   bit          rr = 1'b0;
   logic [11:0] blk = '0;

   logic        hist [0:4];
   bit          spur = 1'b0;

   logic [15:0] addr_q[$];
   logic [2:0]  off_q[$];
   bit          gseq[$];
   int          g_cyc = 0, d_cyc = 0;
   bit          prev_busy = 1'b0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                    name, act, exp, cyc);
   endtask

   task automatic model_step();
      if (phase == 12) begin
         phase = -1;
`ifdef ARB_ROUND_ROBIN_EN
         rr = owner_d;
`endif
      end else if (phase >= 0) begin
         phase++;
      end else if (icache_req || dcache_req) begin
         owner_d = dcache_req && (!icache_req || !rr);
         blk     = owner_d ? dcache_addr[15:4] : icache_addr[15:4];
         phase   = 0;
      end
   endtask

   task automatic compare();
      bit act;
      act = (phase >= 0);
      chk("busy", busy, act);
      chk("icache_grant", icache_grant, act && !owner_d);
      chk("dcache_grant", dcache_grant, act && owner_d);
      chk("mem_en", mem_en, phase >= 0 && phase <= 7);
      if (phase >= 0 && phase <= 7)
         chk("mem_addr", mem_addr, {blk, 3'(phase), 1'b0});
      chk("fill_done", fill_done, phase == 12);
      chk("fill_valid", fill_valid,
          mem_data_valid && phase >= 0 && phase <= 11);
      chk("fill_offset", fill_offset,
          (phase >= 4 && phase <= 11) ? phase - 4 : 0);
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step();
      #1;
      for (int k = 4; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = mem_en;
      mem_data_valid = hist[4] | spur;
      spur = 1'b0;
      #1;
      cyc++;
      compare();
      if (busy && !prev_busy) begin
         g_cyc = cyc;
         gseq.push_back(dcache_grant);
      end
      prev_busy = busy;
      if (mem_en) addr_q.push_back(mem_addr);
      if (fill_valid) off_q.push_back(fill_offset);
      if (fill_done) d_cyc = cyc;
   endtask

   task automatic wait_fill(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick();
         seen = fill_done;
      end
      chk({name, " fill_done seen"}, seen, 1'b1);
   endtask

   task automatic clear_logs();
      addr_q.delete();
      off_q.delete();
      gseq.delete();
   endtask

   initial begin
      int dc, nv, nf;
      for (int k = 0; k <= 4; k++) hist[k] = 1'b0;
      rst_n = 1'b0;
      icache_req = 1'b0; dcache_req = 1'b0;
      icache_addr = '0; dcache_addr = '0;
      mem_data_valid = 1'b0;
      tick();
      tick();
      chk("reset mem_addr", mem_addr, 16'h0000);
      chk("reset mem_en", mem_en, 1'b0);
      chk("reset busy", busy, 1'b0);
      chk("reset grants", {icache_grant, dcache_grant}, 2'b00);
      chk("reset fill_offset", fill_offset, 3'd0);
      chk("reset fill_done", fill_done, 1'b0);
      rst_n = 1'b1;
      tick();

      // Single dcache fill at 0x1234.
      clear_logs();
      dcache_req = 1'b1; dcache_addr = 16'h1234;
      wait_fill("d1234");
      dcache_req = 1'b0;
      chk("d1234 issues", addr_q.size(), 8);
      for (int i = 0; i < 8 && i < addr_q.size(); i++)
         chk("d1234 addr", addr_q[i], 16'h1230 + 16'(2 * i));
      chk("d1234 returns", off_q.size(), 8);
      for (int i = 0; i < 8 && i < off_q.size(); i++)
         chk("d1234 offset", off_q[i], i);
      chk("d1234 latency", d_cyc - g_cyc, 12);
      chk("d1234 owner", gseq.size() > 0 && gseq[0], 1'b1);
      tick(); tick();

      // Simultaneous requests: dcache first, icache after one idle cycle.
      clear_logs();
      icache_req = 1'b1; icache_addr = 16'h0100;
      dcache_req = 1'b1; dcache_addr = 16'h2200;
      wait_fill("tie first");
      dcache_req = 1'b0;
      dc = d_cyc;
      wait_fill("tie second");
      icache_req = 1'b0;
      chk("tie grant count", gseq.size(), 2);
      chk("tie first is d", gseq.size() > 0 && gseq[0], 1'b1);
      chk("tie second is i", gseq.size() > 1 && !gseq[1], 1'b1);
      chk("tie idle gap", g_cyc - dc, 2);
      tick(); tick();

      // Address change mid-fill must not leak into the issue stream.
      clear_logs();
      icache_req = 1'b1; icache_addr = 16'h0040;
      tick();
      icache_addr = 16'h8000;
      wait_fill("addr hold");
      icache_req = 1'b0;
      chk("addr hold issues", addr_q.size(), 8);
      for (int i = 0; i < 8 && i < addr_q.size(); i++)
         chk("addr hold addr", addr_q[i], 16'h0040 + 16'(2 * i));
      tick(); tick();

      // Stray return data while idle.
      spur = 1'b1;
      tick();
      chk("idle stray valid", mem_data_valid, 1'b1);
      chk("idle stray fill_valid", fill_valid, 1'b0);
      chk("idle stray busy", busy, 1'b0);
      tick();
      chk("idle after stray busy", busy, 1'b0);

      // Reset in the 5th FILL cycle aborts the fill.
      dcache_req = 1'b1; dcache_addr = 16'h5670;
      for (int i = 0; i < 20 && phase != 4; i++) tick();
      chk("abort reached fill", mem_en, 1'b1);
      dcache_req = 1'b0;
      rst_n = 1'b0;
      phase = -1;
      rr = 1'b0;
      #1;
      chk("abort mem_en", mem_en, 1'b0);
      chk("abort mem_addr", mem_addr, 16'h0000);
      chk("abort grants", {icache_grant, dcache_grant}, 2'b00);
      chk("abort fill_valid", fill_valid, 1'b0);
      chk("abort fill_offset", fill_offset, 3'd0);
      chk("abort fill_done", fill_done, 1'b0);
      chk("abort busy", busy, 1'b0);
      nv = 0; nf = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i == 0) rst_n = 1'b1;
         nv += int'(mem_data_valid);
         nf += int'(fill_valid);
      end
      chk("abort late valids", nv, 4);
      chk("abort late fill_valid", nf, 0);

      // Both requests held across four fills.
      clear_logs();
      icache_req = 1'b1; icache_addr = 16'h3000;
      dcache_req = 1'b1; dcache_addr = 16'h4000;
      for (int f = 0; f < 4; f++) wait_fill("held");
      icache_req = 1'b0; dcache_req = 1'b0;
      chk("held grants", gseq.size(), 4);
      for (int f = 0; f < 4 && f < gseq.size(); f++)
`ifdef ARB_ROUND_ROBIN_EN
         chk("held rr order", gseq[f], (f % 2) == 0);
`else
         chk("held fixed order", gseq[f], 1'b1);
`endif
      tick(); tick();

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         tick();
         if (phase == 12 && owner_d) dcache_req = 1'b0;
         else if (!dcache_req && $urandom_range(3) == 0) begin
            dcache_req = 1'b1;
            dcache_addr = 16'($urandom);
         end
         if (phase == 12 && !owner_d) icache_req = 1'b0;
         else if (!icache_req && $urandom_range(3) == 0) begin
            icache_req = 1'b1;
            icache_addr = 16'($urandom);
         end
         if (phase >= 0 && phase < 12) begin
            if (owner_d) dcache_addr = 16'($urandom);
            else icache_addr = 16'($urandom);
         end
         if (!dcache_req) dcache_addr = 16'($urandom);
         if (!icache_req) icache_addr = 16'($urandom);
         if (phase == -1 && !icache_req && !dcache_req &&
             $urandom_range(7) == 0)
            spur = 1'b1;
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
